// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and state encoding for the instruction fetch block.
package fetch_pkg;

  localparam int FETCH_ADDR_W     = 8;
  localparam int FETCH_DATA_W     = 8;
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    FC_IDLE   = 2'd0,
    FC_FETCH  = 2'd1,
    FC_HALTED = 2'd2
  } fc_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO; flush empties it in one cycle and wins over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Program counter, fetch sequencing and prefetch buffering in front of the decode stage.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   FC_IDLE   | after reset, no fetches until start
//   FC_FETCH  | one fetch per cycle while the prefetch buffer has room
//   FC_HALTED | fetching stopped by halt_req, buffer still drains
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = FETCH_ADDR_W,
  parameter int DATA_W     = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              running
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fc_state_t                  state;
  logic [ADDR_W-1:0]          pc;
  logic [CNT_W-1:0]           fifo_count;
  logic [ADDR_W+DATA_W-1:0]   fifo_dout;
  logic                       push;
  logic                       pop;
  logic                       resume;

  assign imem_addr             = pc;
  assign instr_valid           = (fifo_count != '0);
  assign {instr_pc, instr_data} = fifo_dout;

  // A redirect throws away whatever would have moved through the buffer this cycle.
  assign pop    = instr_valid && instr_ready && !redirect_valid;
  assign push   = (state == FC_FETCH) && !redirect_valid &&
                  ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
  assign resume = start && !halt_req && (state != FC_FETCH);

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc, imem_data}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FC_IDLE;
      pc      <= RESET_PC;
      running <= 1'b0;
    end else begin
      if (redirect_valid) pc <= redirect_target;
      else if (push)      pc <= pc + ADDR_W'(1);

      // Redirect leaves the state alone apart from a concurrent start.
      if (resume) begin
        state   <= FC_FETCH;
        running <= 1'b1;
      end else if (!redirect_valid) begin
        case (state)
          FC_IDLE, FC_HALTED: ;
          FC_FETCH: begin
            if (halt_req) begin
              state   <= FC_HALTED;
              running <= 1'b0;
            end
          end
          default: begin
            state   <= FC_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
